// File: rtl/decade_pkg.sv
// Shared BCD constants and the load-value validity check for the decade counter.
package decade_pkg;

    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // A digit value is legal only in 0..9; 10..15 must never reach the display decoder.
    function automatic logic bcd_valid(input logic [3:0] din);
        return din <= BCD_MAX;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles; DIV=1 passes en straight through.
module tick_gen #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    // Minimum width that holds DIV-1, never narrower than one bit.
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV <= 1) begin : g_bypass
            // No prescaler state: every enabled cycle is a step.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, restart};
            assign tick = en;
        end else begin : g_prescale
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt;

            assign tick = en && (cnt == LAST);

            // Count 0..DIV-1 while enabled; restart wins so a clr/load realigns the period.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (restart) begin
                    cnt <= '0;
                end else if (en) begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/decade_counter_bcd.sv
// Single BCD digit (0-9) with prescaler, up/down, clear, load and a cascade wrap pulse.
module decade_counter_bcd
    import decade_pkg::*;
#(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] q,
    output logic       step,
    output logic       cout
);

    logic       tick;
    logic       load_ok;
    logic       restart;
    logic [3:0] q_next;
    logic       wrap;

    // Out-of-range loads are dropped entirely, so they neither touch q nor the prescaler phase.
    assign load_ok = load && bcd_valid(din);
    assign restart = clr || load_ok;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (restart),
        .tick    (tick)
    );

    // Next counted value and wrap detection for the current direction.
    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        if (up) begin
            if (q >= BCD_MAX) begin
                q_next = BCD_MIN;
                wrap   = 1'b1;
            end else begin
                q_next = q + 4'd1;
            end
        end else begin
            if (q == BCD_MIN) begin
                q_next = BCD_MAX;
                wrap   = 1'b1;
            end else begin
                q_next = q - 4'd1;
            end
        end
    end

    // Digit and pulse registers; priority is clr, accepted load, tick, hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= BCD_MIN;
            step <= 1'b0;
            cout <= 1'b0;
        end else begin
            step <= 1'b0;
            cout <= 1'b0;
            if (clr) begin
                q <= BCD_MIN;
            end else if (load_ok) begin
                q <= din;
            end else if (tick) begin
                q    <= q_next;
                step <= 1'b1;
                cout <= wrap;
            end
        end
    end

endmodule

// File: tb/tb_decade_counter_bcd.sv
// Directed bench for decade_counter_bcd: DIV=4 digit plus a DIV=1 digit that can be chained.
module tb_decade_counter_bcd;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] din = 4'd0;
    logic [3:0] q4;
    logic       step4, cout4;

    logic       en1_drv = 1'b0, up1 = 1'b1, clr1 = 1'b0, load1 = 1'b0, chain = 1'b0;
    logic [3:0] din1 = 4'd0;
    logic       en1;
    logic [3:0] q1;
    logic       step1, cout1;

    int errors = 0;
    int checks = 0;

    logic [3:0] eq;
    logic       es, ec;

    assign en1 = chain ? cout4 : en1_drv;

    always #5 clk = ~clk;

    decade_counter_bcd #(.DIV(4)) dut4 (
        .clk (clk), .rst (rst), .en (en), .up (up), .clr (clr), .load (load), .din (din),
        .q (q4), .step (step4), .cout (cout4)
    );

    decade_counter_bcd #(.DIV(1)) dut1 (
        .clk (clk), .rst (rst), .en (en1), .up (up1), .clr (clr1), .load (load1), .din (din1),
        .q (q1), .step (step1), .cout (cout1)
    );

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; din = 4'd0;
        en1_drv = 1'b0; up1 = 1'b1; clr1 = 1'b0; load1 = 1'b0; din1 = 4'd0; chain = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q4, step4, cout4} !== 6'b0) begin
            errors++;
            $display("FAIL reset_div4: got q=%0d step=%b cout=%b, want 0 0 0", q4, step4, cout4);
        end
        checks++;
        if ({q1, step1, cout1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_div1: got q=%0d step=%b cout=%b, want 0 0 0", q1, step1, cout1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        apply_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            next_edge();
            eq = 4'((k / 4) % 10);
            es = (k % 4) == 0;
            ec = (k == 40);
            checks++;
            if ({q4, step4, cout4} !== {eq, es, ec}) begin
                errors++;
                $display("FAIL count_up edge %0d: got q=%0d step=%b cout=%b, want q=%0d step=%b cout=%b",
                         k, q4, step4, cout4, eq, es, ec);
            end
        end
    endtask

    task automatic test_count_down();
        apply_reset();
        en = 1'b1; up = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_edge();
            if (k == 4 || k == 5 || k == 8) begin
                eq = (k == 8) ? 4'd8 : 4'd9;
                es = (k != 5);
                ec = (k == 4);
                checks++;
                if ({q4, step4, cout4} !== {eq, es, ec}) begin
                    errors++;
                    $display("FAIL count_down edge %0d: got q=%0d step=%b cout=%b, want q=%0d step=%b cout=%b",
                             k, q4, step4, cout4, eq, es, ec);
                end
            end
        end
    endtask

    task automatic test_load();
        apply_reset();
        en = 1'b1; up = 1'b1;
        next_edge(); next_edge();
        load = 1'b1; din = 4'd7;
        for (int k = 3; k <= 11; k++) begin
            next_edge();
            if (k == 3) load = 1'b0;
            if (k == 8) begin load = 1'b1; din = 4'd12; end
            eq = 4'bx; es = 1'b0;
            if (k == 3 || k == 4 || k == 6) eq = 4'd7;
            if (k == 7) begin eq = 4'd8; es = 1'b1; end
            if (k == 9 || k == 10) eq = 4'd8;
            if (k == 11) begin eq = 4'd9; es = 1'b1; end
            if (k != 5 && k != 8) begin
                checks++;
                if ({q4, step4, cout4} !== {eq, es, 1'b0}) begin
                    errors++;
                    $display("FAIL load edge %0d: got q=%0d step=%b cout=%b, want q=%0d step=%b cout=0",
                             k, q4, step4, cout4, eq, es);
                end
            end
        end
        load = 1'b0; din = 4'd0;
    endtask

    task automatic test_clr_priority();
        apply_reset();
        en = 1'b1; up = 1'b1; load = 1'b1; din = 4'd5;
        next_edge();
        load = 1'b0;
        checks++;
        if (q4 !== 4'd5) begin
            errors++;
            $display("FAIL clr_setup_load5: got q=%0d, want q=5", q4);
        end
        next_edge(); next_edge(); next_edge();
        clr = 1'b1; load = 1'b1; din = 4'd3;
        next_edge();
        clr = 1'b0; load = 1'b0;
        checks++;
        if ({q4, step4, cout4} !== 6'b0) begin
            errors++;
            $display("FAIL clr_over_tick: got q=%0d step=%b cout=%b, want 0 0 0", q4, step4, cout4);
        end
        next_edge(); next_edge(); next_edge();
        checks++;
        if ({q4, step4, cout4} !== 6'b0) begin
            errors++;
            $display("FAIL clr_restart_early: got q=%0d step=%b cout=%b, want 0 0 0", q4, step4, cout4);
        end
        next_edge();
        checks++;
        if ({q4, step4, cout4} !== {4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clr_restart_step: got q=%0d step=%b cout=%b, want 1 1 0", q4, step4, cout4);
        end
    endtask

    task automatic test_enable_and_dir();
        apply_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            next_edge();
            if (k == 2) en = 1'b0;
            if (k == 4) en = 1'b1;
            if (k == 7) up = 1'b0;
            if (k == 11) up = 1'b1;
            if (k == 12) up = 1'b0;
            eq = 4'bx; es = 1'b0; ec = 1'b0;
            if (k == 4 || k == 5) eq = 4'd0;
            if (k == 6) begin eq = 4'd1; es = 1'b1; end
            if (k == 9) eq = 4'd1;
            if (k == 10) begin eq = 4'd0; es = 1'b1; end
            if (k == 14) begin eq = 4'd9; es = 1'b1; ec = 1'b1; end
            if (k == 4 || k == 5 || k == 6 || k == 9 || k == 10 || k == 14) begin
                checks++;
                if ({q4, step4, cout4} !== {eq, es, ec}) begin
                    errors++;
                    $display("FAIL en_dir edge %0d: got q=%0d step=%b cout=%b, want q=%0d step=%b cout=%b",
                             k, q4, step4, cout4, eq, es, ec);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; up = 1'b1; load = 1'b1; din = 4'd5;
        next_edge();
        load = 1'b0;
        next_edge(); next_edge(); next_edge(); next_edge();
        checks++;
        if ({q4, step4, cout4} !== {4'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_setup: got q=%0d step=%b cout=%b, want 6 1 0", q4, step4, cout4);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({q4, step4, cout4} !== 6'b0) begin
            errors++;
            $display("FAIL async_rst_no_edge: got q=%0d step=%b cout=%b, want 0 0 0", q4, step4, cout4);
        end
        @(negedge clk);
        rst = 1'b0;
        next_edge(); next_edge();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        next_edge(); next_edge(); next_edge();
        checks++;
        if ({q4, step4, cout4} !== 6'b0) begin
            errors++;
            $display("FAIL async_discard_phase: got q=%0d step=%b cout=%b, want 0 0 0", q4, step4, cout4);
        end
        next_edge();
        checks++;
        if ({q4, step4, cout4} !== {4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_first_step: got q=%0d step=%b cout=%b, want 1 1 0", q4, step4, cout4);
        end
    endtask

    task automatic test_div1();
        apply_reset();
        en1_drv = 1'b1; up1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            next_edge();
            eq = 4'(k % 10);
            ec = (k % 10) == 0;
            checks++;
            if ({q1, step1, cout1} !== {eq, 1'b1, ec}) begin
                errors++;
                $display("FAIL div1 edge %0d: got q=%0d step=%b cout=%b, want q=%0d step=1 cout=%b",
                         k, q1, step1, cout1, eq, ec);
            end
        end
        en1_drv = 1'b0;
    endtask

    task automatic test_cascade();
        apply_reset();
        chain = 1'b1; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            next_edge();
            if (k >= 40) begin
                eq = (k == 40) ? 4'd0 : 4'd1;
                es = (k == 41);
                checks++;
                if ({q1, step1, cout1} !== {eq, es, 1'b0}) begin
                    errors++;
                    $display("FAIL cascade edge %0d: tens q=%0d step=%b cout=%b, want q=%0d step=%b cout=0",
                             k, q1, step1, cout1, eq, es);
                end
            end
        end
        chain = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_clr_priority();
        test_enable_and_dir();
        test_async_reset();
        test_div1();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
